// File: rtl/ft245_pkg.sv
// ft245_pkg: shared state encoding and constants for the FT245 FIFO responder.
package ft245_pkg;

    localparam int unsigned FT_BYTE_W      = 8;
    localparam int unsigned FT_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ACTIVE,
        ST_RD_RECOVER,
        ST_WR_ACTIVE,
        ST_WR_RECOVER
    } ft_state_t;

endpackage

// File: rtl/ft245_fifo_responder_fifo.sv
// ft_sync_fifo: single-clock byte queue with combinational head, full/empty and level.
module ft_sync_fifo
    import ft245_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [FT_BYTE_W-1:0]   push_data,
    input  logic                   pop,
    output logic [FT_BYTE_W-1:0]   head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [FT_BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ft245_fifo_responder.sv
// ft245_fifo_responder: device side of the FT232H/FT245 asynchronous FIFO bus.
// Define FT245_LOOPBACK_EN to push master-written bytes back into the read queue.
module ft245_fifo_responder
    import ft245_pkg::*;
#(
    parameter int unsigned DEPTH            = 16,
    parameter int unsigned RXF_INACTIVE_CYC = 4,
    parameter int unsigned TXE_INACTIVE_CYC = 4
) (
    input  logic                   CLOCK_50,
    input  logic                   reset_n,
    input  logic [7:0]             host_tx_data,
    input  logic                   host_tx_valid,
    output logic                   host_tx_ready,
    output logic [7:0]             host_rx_data,
    output logic                   host_rx_valid,
    input  logic                   host_rx_ready,
    output logic                   RXF_n,
    output logic                   TXE_n,
    input  logic                   RD_n,
    input  logic                   WR_n,
    input  logic [7:0]             data_in,
    output logic [7:0]             data_out,
    output logic                   data_oe,
    output logic [$clog2(DEPTH):0] tx_level,
    output logic [$clog2(DEPTH):0] rx_level,
    output logic                   protocol_err
);

    logic [FT_SYNC_STAGES-1:0]                rd_sync;
    logic [FT_SYNC_STAGES-1:0]                wr_sync;
    logic [FT_SYNC_STAGES-1:0][FT_BYTE_W-1:0] din_pipe;
    logic                                     rd_prev;
    logic                                     wr_prev;
    logic                                     rd_s;
    logic                                     wr_s;
    logic [FT_BYTE_W-1:0]                     din_s;
    logic                                     rd_fall;
    logic                                     rd_rise;
    logic                                     wr_fall;
    logic                                     wr_rise;
    logic                                     both_low;

    ft_state_t   state_q;
    ft_state_t   state_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        rst_done;
    logic        fsm_pop;
    logic        fsm_push;
    logic        err_set;

    logic                 tx_push;
    logic [FT_BYTE_W-1:0] tx_wdata;
    logic                 tx_pop;
    logic [FT_BYTE_W-1:0] tx_head;
    logic                 tx_full;
    logic                 tx_empty;
    logic                 rx_push;
    logic                 rx_pop;
    logic                 rx_full;
    logic                 rx_empty;
    logic                 tgt_full;
    logic                 rxf_idle;
    logic                 txe_idle;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            rd_sync  <= '1;
            wr_sync  <= '1;
            din_pipe <= '0;
            rd_prev  <= 1'b1;
            wr_prev  <= 1'b1;
        end else begin
            rd_sync  <= {rd_sync[FT_SYNC_STAGES-2:0], RD_n};
            wr_sync  <= {wr_sync[FT_SYNC_STAGES-2:0], WR_n};
            din_pipe <= {din_pipe[FT_SYNC_STAGES-2:0], data_in};
            rd_prev  <= rd_s;
            wr_prev  <= wr_s;
        end
    end

    assign rd_s     = rd_sync[FT_SYNC_STAGES-1];
    assign wr_s     = wr_sync[FT_SYNC_STAGES-1];
    assign din_s    = din_pipe[FT_SYNC_STAGES-1];
    assign rd_fall  = rd_prev & ~rd_s;
    assign rd_rise  = ~rd_prev & rd_s;
    assign wr_fall  = wr_prev & ~wr_s;
    assign wr_rise  = ~wr_prev & wr_s;
    assign both_low = ~rd_s & ~wr_s;

    // Flags stay deasserted for the first cycle out of reset so both read high during reset.
    assign rxf_idle = tx_empty | ~rst_done;
    assign txe_idle = tgt_full | ~rst_done;

`ifdef FT245_LOOPBACK_EN
    assign tgt_full      = tx_full;
    assign host_tx_ready = ~tx_full & ~fsm_push;
    assign tx_push       = fsm_push | (host_tx_valid & host_tx_ready);
    assign tx_wdata      = fsm_push ? din_s : host_tx_data;
    assign rx_push       = 1'b0;
    assign rx_pop        = 1'b0;
    assign host_rx_valid = 1'b0;
`else
    assign tgt_full      = rx_full;
    assign host_tx_ready = ~tx_full;
    assign tx_push       = host_tx_valid & host_tx_ready;
    assign tx_wdata      = host_tx_data;
    assign rx_push       = fsm_push;
    assign rx_pop        = host_rx_valid & host_rx_ready;
    assign host_rx_valid = ~rx_empty;
`endif
    assign tx_pop = fsm_pop;

    ft_sync_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk       (CLOCK_50),
        .rst_n     (reset_n),
        .push      (tx_push),
        .push_data (tx_wdata),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    ft_sync_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk       (CLOCK_50),
        .rst_n     (reset_n),
        .push      (rx_push),
        .push_data (din_s),
        .pop       (rx_pop),
        .head      (host_rx_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rst_done     <= 1'b0;
            data_out     <= '0;
            protocol_err <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rst_done     <= 1'b1;
            data_out     <= tx_empty ? '0 : tx_head;
            protocol_err <= protocol_err | err_set;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fsm_pop  = 1'b0;
        fsm_push = 1'b0;
        RXF_n    = rxf_idle;
        TXE_n    = txe_idle;
        unique case (state_q)
            ST_IDLE: begin
                if (!both_low) begin
                    if (rd_fall && !rxf_idle) begin
                        state_d = ST_RD_ACTIVE;
                    end else if (wr_fall && !txe_idle) begin
                        fsm_push = 1'b1;
                        state_d  = ST_WR_ACTIVE;
                    end
                end
            end
            ST_RD_ACTIVE: begin
                RXF_n = 1'b0;
                if (rd_rise) begin
                    fsm_pop = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RD_RECOVER;
                end
            end
            ST_RD_RECOVER: begin
                RXF_n = 1'b1;
                if (cnt_q == 16'(RXF_INACTIVE_CYC - 1)) state_d = ST_IDLE;
                else                                    cnt_d   = cnt_q + 16'd1;
            end
            ST_WR_ACTIVE: begin
                TXE_n = tgt_full;
                if (wr_rise) begin
                    cnt_d   = '0;
                    state_d = ST_WR_RECOVER;
                end
            end
            ST_WR_RECOVER: begin
                TXE_n = 1'b1;
                if (cnt_q == 16'(TXE_INACTIVE_CYC - 1)) state_d = ST_IDLE;
                else                                    cnt_d   = cnt_q + 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase
        err_set = (rd_fall & RXF_n) | (wr_fall & TXE_n) | both_low;
    end

    // Raw RD_n gates the driver so the byte is on the bus inside the master's sample window.
    assign data_oe = ~RD_n & ((state_q == ST_IDLE) | (state_q == ST_RD_ACTIVE)) & ~tx_empty;

endmodule

// File: doc/ft245_fifo_responder.md
Name: ft245_fifo_responder

Overview:
- Synthesizable model of the FT232H/FT245 asynchronous-FIFO device side: the responder to our FPGA-side USB master.
- Presents RXF_n/TXE_n, serves bytes on RD_n strobes and captures bytes on WR_n strobes.
- Host-side byte streams connect through valid/ready ports.
- Used for board-level loopback wiring to the master's GPIO pins and as a cycle-accurate bench partner.

Parameters:
- DEPTH, 16, entries per internal queue; power of two, minimum 2.
- RXF_INACTIVE_CYC, 4, CLOCK_50 cycles RXF_n is held high after each completed read.
- TXE_INACTIVE_CYC, 4, CLOCK_50 cycles TXE_n is held high after each completed write.

Ports:
- CLOCK_50  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- host_tx_data  in  8  byte queued toward the FPGA master (read direction).
- host_tx_valid  in  1  host_tx_data valid.
- host_tx_ready  out  1  tx queue not full.
- host_rx_data  out  8  byte written by the master.
- host_rx_valid  out  1  rx queue not empty.
- host_rx_ready  in  1  host consumes host_rx_data.
- RXF_n  out  1  low = byte available to read.
- TXE_n  out  1  low = space available to write.
- RD_n  in  1  master read strobe, asynchronous.
- WR_n  in  1  master write strobe, asynchronous.
- data_in  in  8  bus value driven by the master.
- data_out  out  8  bus value driven by the responder.
- data_oe  out  1  responder drives the bus.
- tx_level  out  $clog2(DEPTH)+1  tx queue occupancy.
- rx_level  out  $clog2(DEPTH)+1  rx queue occupancy.
- protocol_err  out  1  sticky error flag.

Behaviour:
- Reset values (asynchronous, while reset_n low):
  - Both queues empty, FSM in IDLE.
  - RXF_n=1, TXE_n=1, data_oe=0, data_out=0, protocol_err=0, levels=0.
  - host_tx_ready=1, host_rx_valid=0.
- Synchronisation:
  - RD_n and WR_n each pass through 2-flop synchronisers, reset value 1.
  - data_in passes through a matched 2-stage pipeline so the byte stays aligned with the synced WR_n.
  - Edges are detected on the synced signals.
- FSM states: IDLE, RD_ACTIVE, RD_RECOVER, WR_ACTIVE, WR_RECOVER.
- IDLE:
  - RXF_n = (tx empty), TXE_n = (rx full).
  - Synced RD_n falling with RXF_n low → RD_ACTIVE.
  - Else synced WR_n falling with TXE_n low → WR_ACTIVE.
  - Both falling in the same cycle → protocol_err=1, stay in IDLE.
- Read path:
  - data_out is registered and always equals the tx queue head.
  - data_oe = ~RD_n (raw) AND (state is IDLE or RD_ACTIVE) AND tx non-empty. The combinational path from the raw pin is intentional so data is valid within the master's 2-cycle sample window.
  - In RD_ACTIVE, synced RD_n rising → pop the tx queue, go to RD_RECOVER with RXF_n=1.
  - RD_RECOVER counts RXF_INACTIVE_CYC cycles, then → IDLE.
- Write path:
  - On the synced WR_n falling edge, push the pipelined data_in byte into the rx queue and enter WR_ACTIVE.
  - WR_ACTIVE waits for synced WR_n rising → WR_RECOVER with TXE_n=1.
  - WR_RECOVER counts TXE_INACTIVE_CYC cycles, then → IDLE.
- Errors (protocol_err is sticky until reset; the offending strobe is otherwise ignored):
  - RD_n falling while RXF_n=1.
  - WR_n falling while TXE_n=1.
  - RD_n and WR_n both low simultaneously.
- Host ports:
  - Standard valid/ready; transfer occurs when both are high at the clock edge.
  - A simultaneous host push and FSM pop on the same queue is allowed; level is unchanged.
  - A push into a full queue is blocked by ready=0.
  - Pointers wrap modulo DEPTH; level saturates at DEPTH.
- A strobe held low across RD_RECOVER/WR_RECOVER does not re-trigger; only a fresh falling edge in IDLE counts.

Optional Feature:
- FT245_LOOPBACK_EN defined:
  - A byte captured on WR_n is pushed into the tx queue instead of the rx queue.
  - TXE_n tracks tx-full.
  - host_rx_valid is tied to 0.
  - host_tx_ready = 0 whenever a loopback push occurs that cycle; the loopback push has priority.
- Undefined: the two queues are independent, as above.

Decomposition:
- Package ft245_pkg:
  - State enum (ft_state_t).
  - Byte width constant (FT_BYTE_W = 8).
  - Synchroniser depth constant (FT_SYNC_STAGES = 2).
- Sub-module ft_sync_fifo (DEPTH, 8-bit, push/pop, full/empty/level), instantiated twice.

Test Plan:
- Push 0xA5, 0x3C from the host → RXF_n falls ≤2 cycles later. Master-style RD_n low for 3 cycles → data_out=0xA5 with data_oe=1. After RD_n rises, RXF_n stays high for exactly 4 cycles, then falls with data_out=0x3C.
- Master drives 0x5A on data_in, WR_n low for 2 cycles → host_rx_data=0x5A, host_rx_valid=1. TXE_n stays high for 4 cycles after WR_n rises.
- Write 16 bytes without host consumption → TXE_n stays high after the 16th. A 17th WR_n pulse sets protocol_err; rx_level=16.
- RD_n pulse with the tx queue empty → data_oe stays 0, protocol_err=1, tx_level unchanged.
- Deassert reset_n mid-read (RD_n low, state RD_ACTIVE) → all outputs return to reset values immediately. After release, RXF_n=1 and the queues are empty.
- With FT245_LOOPBACK_EN: write 0x11, 0x22 → RXF_n falls, and subsequent reads return 0x11 then 0x22.
